// File: rtl/div32_seq_if.sv
// div32_seq_if: handshake and operand/result bundle between the control unit
// and the iterative divider.
//   start, is_signed, dividend, divisor : request side, driven by the controller
//   busy, ready, q, r, dbz              : status/result side, driven by the divider
// master = control unit view, slave = divider view.
interface div32_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        ready;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, ready, q, r, dbz
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, ready, q, r, dbz
    );
endinterface

// File: rtl/div32_seq.sv
// addsub32: 32-bit adder/subtractor used as the per-step engine of div32_seq.
//   a, b : operands
//   sub  : 1 = a - b, 0 = a + b
//   s    : result modulo 2^32
module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] s
);
    assign s = a + (b ^ {32{sub}}) + {31'd0, sub};
endmodule

// div32_seq: iterative 32-bit divider for MIPS DIV/DIVU (LO = quotient,
// HI = remainder). Non-restoring unsigned division on operand magnitudes,
// one quotient bit per cycle, followed by a remainder/sign correction cycle.
//   clk, reset     : clock and synchronous active-high reset
//   bus.start      : request a divide (only honoured in IDLE)
//   bus.is_signed  : 1 = DIV, 0 = DIVU
//   bus.dividend   : rs operand, captured on an accepted start
//   bus.divisor    : rt operand, captured on an accepted start
//   bus.busy       : divide in progress
//   bus.ready      : one-cycle pulse, q/r/dbz valid
//   bus.q, bus.r   : quotient / remainder, held until the next ready
//   bus.dbz        : divisor was zero, held with q/r
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; ready may pulse here for one cycle
// ITER  | 32 non-restoring steps, one quotient bit per cycle
// CORR  | fix negative remainder, apply signs, publish result
module div32_seq #(
    parameter logic [31:0] DBZ_QUOT  = 32'hFFFF_FFFF,
    parameter int          FAST_ZERO = 1
) (
    input  logic       clk,
    input  logic       reset,
    div32_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2
    } state_t;

    state_t      state, state_nx;

    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr_mag;
    logic [31:0] dvd_raw;
    logic        neg_q;
    logic        neg_r;
    logic        zero_div;

    logic [31:0] q_q;
    logic [31:0] r_q;
    logic        dbz_q;
    logic        ready_q;
    logic        busy_c;

    logic        accept;
    logic        fast_dbz;
    logic [31:0] dvd_mag_in;
    logic [31:0] dsr_mag_in;

    logic [31:0] as_a;
    logic [31:0] as_b;
    logic        as_sub;
    logic [31:0] as_s;

    logic [32:0] rem_sh;
    logic        b_eff31;
    logic        c31;
    logic        c32;
    logic        sign_nx;

    logic [31:0] rem_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign accept   = (state == IDLE) && bus.start;
    assign fast_dbz = (FAST_ZERO != 0) && (bus.divisor == 32'd0);

    assign dvd_mag_in = (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
    assign dsr_mag_in = (bus.is_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;

    // Shift {rem,quo} left by one; the 33-bit view keeps the shifted-out bit.
    assign rem_sh = {rem[31:0], quo[31]};

    addsub32 u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (as_sub),
        .s   (as_s)
    );

    // Bit 32 of the new partial remainder. The carry into bit 32 is rebuilt
    // from s[31] and the bit-31 operands, then folded with the shifted sign
    // and the sign-extension of the (possibly inverted) divisor.
    assign b_eff31 = as_b[31] ^ as_sub;
    assign c31     = as_s[31] ^ as_a[31] ^ b_eff31;
    assign c32     = (as_a[31] & b_eff31) | (c31 & (as_a[31] ^ b_eff31));
    assign sign_nx = rem_sh[32] ^ as_sub ^ c32;

    // Final remainder magnitude: in CORR the engine adds the divisor back.
    assign rem_mag = rem[32] ? as_s : rem[31:0];
    assign q_fix   = neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem_mag : rem_mag;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && !fast_dbz) begin
                    state_nx = ITER;
                end
            end
            ITER: begin
                if (cnt == 5'd0) begin
                    state_nx = CORR;
                end
            end
            CORR:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output / engine control logic
    always_comb begin
        busy_c = (state != IDLE);
        as_a   = rem_sh[31:0];
        as_b   = dsr_mag;
        as_sub = ~rem[32];
        if (state == CORR) begin
            as_a   = rem[31:0];
            as_sub = 1'b0;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 5'd0;
            rem      <= 33'd0;
            quo      <= 32'd0;
            dsr_mag  <= 32'd0;
            dvd_raw  <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            q_q      <= 32'd0;
            r_q      <= 32'd0;
            dbz_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fast_dbz) begin
                            q_q     <= DBZ_QUOT;
                            r_q     <= bus.dividend;
                            dbz_q   <= 1'b1;
                            ready_q <= 1'b1;
                        end else begin
                            cnt      <= 5'd31;
                            rem      <= 33'd0;
                            quo      <= dvd_mag_in;
                            dsr_mag  <= dsr_mag_in;
                            dvd_raw  <= bus.dividend;
                            neg_q    <= bus.is_signed && (bus.dividend[31] ^ bus.divisor[31]);
                            neg_r    <= bus.is_signed && bus.dividend[31];
                            zero_div <= (bus.divisor == 32'd0);
                        end
                    end
                end
                ITER: begin
                    rem <= {sign_nx, as_s};
                    // Quotient bit is set when the new remainder is non-negative.
                    quo <= {quo[30:0], ~sign_nx};
                    cnt <= cnt - 5'd1;
                end
                CORR: begin
                    if (zero_div) begin
                        q_q   <= DBZ_QUOT;
                        r_q   <= dvd_raw;
                        dbz_q <= 1'b1;
                    end else begin
                        q_q   <= q_fix;
                        r_q   <= r_fix;
                        dbz_q <= 1'b0;
                    end
                    ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_c;
    assign bus.ready = ready_q;
    assign bus.q     = q_q;
    assign bus.r     = r_q;
    assign bus.dbz   = dbz_q;

endmodule
